cv32e40p_security_marker_scheduler: RTL and testbench

Stream controller between the prefetch buffer and the IF/ID pipeline register. It schedules security markers (JAL x0,0 = 32'h0000006F) into the fetched instruction stream so that no more than WWDL-1 real instructions ever sit between two markers. It inserts markers as extra slots and stalls upstream through a valid/ready handshake, so no fetched instruction is ever overwritten. It optionally pre-empts discontinuity instructions so that a taken branch cannot flush a pending marker.

---
 rtl/cv32e40p_secmark_pkg.sv | 16 +
 rtl/cv32e40p_disc_instr_decoder.sv | 16 +
 rtl/cv32e40p_security_marker_scheduler.sv | 135 +++++++++++++
 tb/tb_cv32e40p_security_marker_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_secmark_pkg.sv
// rtl/cv32e40p_secmark_pkg.sv - shared constants and state type for the security marker scheduler
package cv32e40p_secmark_pkg;

   localparam logic [31:0] SECMARK_INSTR = 32'h0000006F;

   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;

   typedef enum logic [1:0] {
      DISABLED  = 2'd0,
      RUN       = 2'd1,
      HOLD_DISC = 2'd2
   } secmark_state_e;

endpackage

// File: rtl/cv32e40p_disc_instr_decoder.sv
// rtl/cv32e40p_disc_instr_decoder.sv - flags control-flow discontinuities (branch, JAL, JALR)
module cv32e40p_disc_instr_decoder
   import cv32e40p_secmark_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic        is_disc_o
);

   logic [4:0] w_opc;

   assign w_opc     = instr_i[6:2];
   assign is_disc_o = (w_opc == OPC_BRANCH) ||
                      (w_opc == OPC_JAL) ||
                      ((w_opc == OPC_JALR) && (instr_i[14:12] == 3'b000));

endmodule

// File: rtl/cv32e40p_security_marker_scheduler.sv
// rtl/cv32e40p_security_marker_scheduler.sv - injects JAL x0,0 markers so at most WWDL-1 real words sit between markers
// Optional discontinuity pre-emption: CV32E40P_SECMARK_DISC_PREEMPT_EN
module cv32e40p_security_marker_scheduler
   import cv32e40p_secmark_pkg::*;
#(
   parameter int unsigned WWDL = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_i,
   input  logic        flush_i,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_rdata_i,
   output logic        instr_ready_o,
   output logic        instr_valid_o,
   output logic [31:0] instr_rdata_o,
   output logic        marker_o,
   input  logic        instr_ready_i
);

   localparam int unsigned CW = $clog2(WWDL + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WWDL - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_TWO  = CW'(2);

   secmark_state_e r_state, w_state_nxt;
   logic           r_valid, r_marker;
   logic [31:0]    r_rdata;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;

   logic w_slot_free, w_load_en, w_nonzero, w_cnt_zero;
   logic w_is_disc, w_preempt, w_inject;
   logic w_ready, w_ld_word, w_ld_marker;

   cv32e40p_disc_instr_decoder u_disc_dec (
      .instr_i   (instr_rdata_i),
      .is_disc_o (w_is_disc)
   );

   assign w_slot_free = !r_valid || instr_ready_i;
   assign w_load_en   = w_slot_free && !flush_i;
   assign w_nonzero   = |instr_rdata_i;
   assign w_cnt_zero  = (r_cnt == '0);

`ifdef CV32E40P_SECMARK_DISC_PREEMPT_EN
   // Marker goes ahead of a jump that would otherwise leave the window nearly exhausted
   assign w_preempt = w_is_disc && w_nonzero && ((r_cnt == CNT_ONE) || (r_cnt == CNT_TWO));
`else
   logic w_unused_disc;
   assign w_unused_disc = w_is_disc;
   assign w_preempt     = 1'b0;
`endif

   // All-zero words never trigger injection, even with the window exhausted
   assign w_inject = (w_cnt_zero && w_nonzero) || w_preempt;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready     = 1'b0;
      w_ld_word   = 1'b0;
      w_ld_marker = 1'b0;
      case (r_state)
         DISABLED: begin
            w_ready   = w_load_en;
            w_ld_word = w_load_en && instr_valid_i;
            w_cnt_nxt = CNT_INIT;
            if (enable_i) w_state_nxt = RUN;
         end
         RUN: begin
            w_ready = w_load_en && !w_inject;
            if (w_load_en && instr_valid_i) begin
               if (w_inject) begin
                  w_ld_marker = 1'b1;
                  w_cnt_nxt   = CNT_INIT;
               end else begin
                  w_ld_word = 1'b1;
                  if (w_nonzero) w_cnt_nxt = r_cnt - CNT_ONE;
               end
            end
            if (!enable_i)
               w_state_nxt = DISABLED;
            else if (w_load_en && instr_valid_i && w_preempt)
               w_state_nxt = HOLD_DISC;
         end
`ifdef CV32E40P_SECMARK_DISC_PREEMPT_EN
         HOLD_DISC: begin
            w_ready = w_load_en;
            if (w_load_en && instr_valid_i) begin
               w_ld_word   = 1'b1;
               w_cnt_nxt   = r_cnt - CNT_ONE;
               w_state_nxt = enable_i ? RUN : DISABLED;
            end
         end
`endif
         default: w_state_nxt = DISABLED;
      endcase
      // A flushed marker never reached decode, so the next slot must carry one
      if (flush_i) begin
         w_ready     = 1'b0;
         w_state_nxt = enable_i ? RUN : DISABLED;
         w_cnt_nxt   = (r_valid && r_marker) ? '0 : r_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= DISABLED;
         r_valid  <= 1'b0;
         r_marker <= 1'b0;
         r_rdata  <= '0;
         r_cnt    <= CNT_INIT;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (flush_i) begin
            r_valid  <= 1'b0;
            r_marker <= 1'b0;
         end else if (w_load_en) begin
            r_valid  <= w_ld_word || w_ld_marker;
            r_marker <= w_ld_marker;
            if (w_ld_marker)
               r_rdata <= SECMARK_INSTR;
            else if (w_ld_word)
               r_rdata <= instr_rdata_i;
         end
      end
   end

   assign instr_ready_o = w_ready;
   assign instr_valid_o = r_valid;
   assign instr_rdata_o = r_rdata;
   assign marker_o      = r_marker;

endmodule

// File: tb/tb_cv32e40p_security_marker_scheduler.sv
// tb/tb_cv32e40p_security_marker_scheduler.sv - directed vector bench for the security marker scheduler (WWDL=4)
module tb_cv32e40p_security_marker_scheduler;

   localparam int unsigned WWDL = 4;
   localparam logic [31:0] A   = 32'h00100093;
   localparam logic [31:0] B   = 32'h00200113;
   localparam logic [31:0] M   = 32'h0000006F;
   localparam logic [31:0] BEQ = 32'h00000463;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        instr_valid_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic        instr_ready_o;
   logic        instr_valid_o;
   logic [31:0] instr_rdata_o;
   logic        marker_o;
   logic        instr_ready_i = 1'b1;

   int checks = 0;
   int failures = 0;

   cv32e40p_security_marker_scheduler #(.WWDL(WWDL)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (enable_i),
      .flush_i       (flush_i),
      .instr_valid_i (instr_valid_i),
      .instr_rdata_i (instr_rdata_i),
      .instr_ready_o (instr_ready_o),
      .instr_valid_o (instr_valid_o),
      .instr_rdata_o (instr_rdata_o),
      .marker_o      (marker_o),
      .instr_ready_i (instr_ready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        fl;
      logic        v;
      logic [31:0] d;
      logic        ri;
      logic        rdy;
      logic        vo;
      logic [31:0] dout;
      logic        mk;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive at posedge+1, sample ready mid-cycle, return at next posedge+1
   task automatic tick(input logic en, input logic fl, input logic v, input logic [31:0] d,
                       input logic ri, output logic rdy);
      enable_i      = en;
      flush_i       = fl;
      instr_valid_i = v;
      instr_rdata_i = d;
      instr_ready_i = ri;
      #4;
      rdy = instr_ready_o;
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_marker(input string name, input logic [31:0] w, input int exp_real);
      int   n;
      bit   seen;
      int   other;
      logic rdy;
      n = 0;
      seen = 0;
      other = 0;
      for (int c = 0; c < 3 * WWDL && !seen; c++) begin
         tick(1'b1, 1'b0, 1'b1, w, 1'b1, rdy);
         if (instr_valid_o && marker_o && instr_rdata_o == M) seen = 1;
         else if (instr_valid_o && !marker_o && instr_rdata_o == w) n++;
         else if (instr_valid_o) other++;
      end
      chk({name, "_marker_seen"}, 32'(seen), 32'd1);
      chk({name, "_real_before_marker"}, 32'(n), 32'(exp_real));
      chk({name, "_unexpected_words"}, 32'(other), 32'd0);
   endtask

   initial begin
      logic rdy;
      int   bad;

      // {en, fl, v, d, ri, rdy, vo, dout, mk}
      tbl.push_back('{1, 0, 0, A, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 0, 1, M, 1});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 0, 1, M, 1});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      // idle with window exhausted: no injection, ready low for a nonzero word
      tbl.push_back('{1, 0, 0, A, 1, 0, 0, 0, 0});
      // zero word at cnt==0 passes uncounted
      tbl.push_back('{1, 0, 1, 0, 1, 1, 1, 0, 0});
      tbl.push_back('{1, 0, 1, A, 1, 0, 1, M, 1});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      // marker pending, downstream stalled for 5 cycles, held word B must appear once
      tbl.push_back('{1, 0, 1, B, 1, 0, 1, M, 1});
      for (int i = 0; i < 5; i++) tbl.push_back('{1, 0, 1, B, 0, 0, 1, M, 1});
      tbl.push_back('{1, 0, 1, B, 1, 1, 1, B, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 0, 1, M, 1});
      // flush of a marker forces another marker next
      tbl.push_back('{1, 1, 1, A, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, A, 1, 0, 1, M, 1});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});
      // flush coincides with a due injection: flush wins, marker follows
      tbl.push_back('{1, 1, 1, A, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, A, 1, 0, 1, M, 1});
      tbl.push_back('{1, 0, 1, A, 1, 1, 1, A, 0});

      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid_o", 32'(instr_valid_o), 32'd0);
      chk("reset_rdata_o", instr_rdata_o, 32'h0);
      chk("reset_marker_o", 32'(marker_o), 32'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         tick(tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].ri, rdy);
         chk($sformatf("row%0d_ready_o", i), 32'(rdy), 32'(tbl[i].rdy));
         chk($sformatf("row%0d_valid_o", i), 32'(instr_valid_o), 32'(tbl[i].vo));
         chk($sformatf("row%0d_marker_o", i), 32'(marker_o), 32'(tbl[i].mk));
         if (tbl[i].vo) chk($sformatf("row%0d_rdata_o", i), instr_rdata_o, tbl[i].dout);
      end

      // enable falling: current slot still scheduled, then plain pass-through
      tick(1'b0, 1'b0, 1'b1, A, 1'b1, rdy);
      chk("dis_edge_ready_o", 32'(rdy), 32'd1);
      chk("dis_edge_rdata_o", instr_rdata_o, A);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0, 1'b1, B, 1'b1, rdy);
         if (!(rdy && instr_valid_o && !marker_o && instr_rdata_o == B)) bad++;
      end
      chk("disabled_passthrough_bad_slots", 32'(bad), 32'd0);
      tick(1'b1, 1'b0, 1'b0, A, 1'b1, rdy);
      run_until_marker("enable_rise", A, WWDL - 1);

      // reset mid-stream with cnt==1
      tick(1'b1, 1'b0, 1'b1, A, 1'b1, rdy);
      tick(1'b1, 1'b0, 1'b1, A, 1'b1, rdy);
      chk("pre_reset_rdata_o", instr_rdata_o, A);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid_o", 32'(instr_valid_o), 32'd0);
      chk("midrst_rdata_o", instr_rdata_o, 32'h0);
      chk("midrst_marker_o", 32'(marker_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1'b1, 1'b0, 1'b0, A, 1'b1, rdy);
      run_until_marker("after_reset", A, WWDL - 1);

      // discontinuity arriving with cnt==2
      tick(1'b1, 1'b0, 1'b1, A, 1'b1, rdy);
`ifdef CV32E40P_SECMARK_DISC_PREEMPT_EN
      tick(1'b1, 1'b0, 1'b1, BEQ, 1'b1, rdy);
      chk("preempt_ready_o", 32'(rdy), 32'd0);
      chk("preempt_marker_o", 32'(marker_o), 32'd1);
      chk("preempt_rdata_o", instr_rdata_o, M);
      tick(1'b1, 1'b0, 1'b1, BEQ, 1'b1, rdy);
      chk("held_disc_ready_o", 32'(rdy), 32'd1);
      chk("held_disc_rdata_o", instr_rdata_o, BEQ);
      chk("held_disc_marker_o", 32'(marker_o), 32'd0);
      run_until_marker("after_disc", A, WWDL - 2);
`else
      tick(1'b1, 1'b0, 1'b1, BEQ, 1'b1, rdy);
      chk("disc_plain_ready_o", 32'(rdy), 32'd1);
      chk("disc_plain_rdata_o", instr_rdata_o, BEQ);
      chk("disc_plain_marker_o", 32'(marker_o), 32'd0);
      run_until_marker("after_disc", A, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
